// File: rtl/sar_search.sv
// Successive-approximation search: recovers an unsigned value bit by bit from a greater-than oracle.
// Optional abort input enabled by defining SAR_ABORT_EN.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             gt_in_i,
`ifdef SAR_ABORT_EN
  input  logic             abort_i,
`endif
  output logic [WIDTH-1:0] probe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] trial;

  assign trial = acc_q | (WIDTH'(1) << idx_q);

  // Probe one below the trial so that gt_in (X > probe) means X >= trial.
  assign probe_o  = (state_q == StSearch) ? (trial - WIDTH'(1)) : '0;
  assign busy_o   = (state_q == StSearch);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          acc_d   = '0;
          idx_d   = IdxW'(WIDTH - 1);
          state_d = StSearch;
        end else begin
          state_d = StIdle;
        end
      end
      StSearch: begin
`ifdef SAR_ABORT_EN
        if (abort_i) begin
          state_d = StIdle;
        end else
`endif
        begin
          if (gt_in_i) begin
            acc_d = trial;
          end
          if (idx_q == '0) begin
            result_d = acc_d;
            state_d  = StDone;
          end else begin
            idx_d = idx_q - IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: the driver queues expected probes/results, a monitor checks them.
module tb_sar_search;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] x_val = '0;
  logic         gt_in;
  logic [W-1:0] probe_o, result_o;
  logic         busy_o, done_o;

  int checks = 0;
  int errors = 0;
  int exp_probe[$];
  int exp_res[$];

  always #5 clk = ~clk;

  // Behavioural comparator: X > probe, unsigned.
  assign gt_in = (x_val > probe_o);

  sar_search #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .gt_in_i  (gt_in),
`ifdef SAR_ABORT_EN
    .abort_i  (abort),
`endif
    .probe_o  (probe_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Binary search seen from the answer: at bit i the trial keeps X's bits above i and sets bit i.
  task automatic push_search(input int x);
    for (int i = W - 1; i >= 0; i--) begin
      int trial;
      trial = (x & ~((1 << (i + 1)) - 1)) | (1 << i);
      exp_probe.push_back(trial - 1);
    end
    exp_res.push_back(x);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < 4 * W) begin
      tick();
      n++;
    end
  endtask

  task automatic run_search(input int x);
    int n;
    x_val = W'(x);
    push_search(x);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("latency", n, W);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy_o) begin
        if (exp_probe.size() == 0) chk("unexpected_busy", 1, 0);
        else chk("probe", int'(probe_o), exp_probe.pop_front());
      end else begin
        chk("idle_probe", int'(probe_o), 0);
      end
      if (done_o) begin
        if (exp_res.size() == 0) chk("unexpected_done", 1, 0);
        else chk("result", int'(result_o), exp_res.pop_front());
      end
    end
  end

  initial begin
    int n;
    #1;
    chk("rst_probe", int'(probe_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_result", int'(result_o), 0);
    tick();
    reset = 1'b0;
    tick();

    run_search(11);
    tick();
    run_search(0);
    run_search(15);
    tick();

    // Back-to-back with start held high.
    x_val = W'(5);
    push_search(5);
    start = 1'b1;
    tick();
    wait_done(n);
    chk("b2b_latency", n, W);
    x_val = W'(9);
    push_search(9);
    tick();
    start = 1'b0;
    chk("b2b_restart_busy", int'(busy_o), 1);
    wait_done(n);
    chk("b2b_gap", n + 1, W + 1);
    tick();

    // Reset during the second SEARCH cycle.
    x_val = W'(11);
    push_search(11);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    exp_probe.delete();
    exp_res.delete();
    chk("mid_rst_probe", int'(probe_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    chk("mid_rst_result", int'(result_o), 0);
    tick();
    reset = 1'b0;
    tick();
    run_search(11);
    tick();

    // start pulsed during SEARCH must be ignored.
    x_val = W'(6);
    push_search(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("start_in_search_latency", n + 2, W);
    tick();
    chk("no_restart", int'(busy_o), 0);
    tick();

`ifdef SAR_ABORT_EN
    run_search(3);
    tick();
    x_val = W'(6);
    push_search(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_probe.delete();
    exp_res.delete();
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_probe", int'(probe_o), 0);
    chk("abort_result", int'(result_o), 3);
    repeat (W + 2) tick();
    chk("abort_result_held", int'(result_o), 3);
`endif

    // Randomised searches with random idle gaps.
    for (int k = 0; k < 30; k++) begin
      run_search(int'($urandom_range(0, (1 << W) - 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    chk("probe_queue_drained", exp_probe.size(), 0);
    chk("result_queue_drained", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
